// File: rtl/multiword_serial_shifter_if.sv
// Bus between the packet formatter (master) and multiword_serial_shifter (slave):
// word writes, control inputs, FIFO status and the serial output.
interface multiword_serial_shifter_if #(
    parameter int WIDTH = 10
);
    // Write handshake: wr_en is the valid. !full is the ready, and a write is taken on any
    // clk50 edge where wr_en && !full. A write while full is also taken when the shifter pops
    // a word on that same edge. Otherwise a write while full is dropped and sets overflow.
    logic             enable;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             lsb_first;
    logic             full;
    logic             empty;
    logic             busy;
    logic             word_done;
    logic             overflow;
    logic             serial_out;

    modport master (
        output enable, wr_en, wr_data, lsb_first,
        input  full, empty, busy, word_done, overflow, serial_out
    );

    modport slave (
        input  enable, wr_en, wr_data, lsb_first,
        output full, empty, busy, word_done, overflow, serial_out
    );
endinterface

// File: rtl/multiword_serial_shifter.sv
// FIFO-buffered parallel-to-serial shifter. Bits advance on synchronised gclk rises, and words chain back-to-back.
// Build option: define SERIAL_PARITY_EN to append one odd-parity bit after each word.
module multiword_serial_shifter #(
    parameter int WIDTH       = 10,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk50,
    input  logic                       rst_n,
    input  logic                       gclk,
    multiword_serial_shifter_if.slave  bus,
    output logic                       state_dbg
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef SERIAL_PARITY_EN
    localparam int SR_W = WIDTH + 1;
`else
    localparam int SR_W = WIDTH;
`endif
    localparam int BCW = $clog2(SR_W);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   overflow_q, overflow_d;
    logic [0:0]             state_q, state_d;
    logic [SR_W-1:0]        shift_q, shift_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                   lsb_q, lsb_d;
    logic                   word_done_q, word_done_d;

    logic                   rise;
    logic                   push;
    logic                   pop;
    logic [WIDTH-1:0]       head;
    logic [SR_W-1:0]        load_word;

    always_comb begin
        head = mem_q[rd_ptr_q];
`ifdef SERIAL_PARITY_EN
        // The parity bit sits behind the data at whichever end shifts out last.
        load_word = bus.lsb_first ? {~(^head), head} : {head, ~(^head)};
`else
        load_word = head;
`endif
    end

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], gclk};
        hist_d      = sync_q[SYNC_STAGES-1];
        rise        = sync_q[SYNC_STAGES-1] & ~hist_q;
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        lsb_d       = lsb_q;
        word_done_d = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    pop = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (rise) begin
                    if (bit_cnt_q == '0) begin
                        word_done_d = 1'b1;
                        if (!empty_q) begin
                            pop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shift_d   = lsb_q ? {1'b0, shift_q[SR_W-1:1]}
                                          : {shift_q[SR_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - BCW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            shift_d   = load_word;
            lsb_d     = bus.lsb_first;
            bit_cnt_d = BCW'(SR_W - 1);
            state_d   = ST_SHIFT;
        end

        // A pop frees a slot on the same edge, so a write at full is still taken then.
        push       = bus.wr_en && (!full_q || pop);
        overflow_d = overflow_q || (bus.wr_en && full_q && !pop);
        count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);

        if (!bus.enable) begin
            sync_d      = '0;
            hist_d      = 1'b0;
            state_d     = ST_IDLE;
            shift_d     = '0;
            bit_cnt_d   = '0;
            lsb_d       = 1'b0;
            word_done_d = 1'b0;
            pop         = 1'b0;
            push        = 1'b0;
            overflow_d  = 1'b0;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            full_d      = 1'b0;
            empty_d     = 1'b1;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            hist_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            lsb_q       <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            lsb_q       <= lsb_d;
            word_done_q <= word_done_d;
        end
    end

    // Storage needs no reset: the count and the pointers decide what is valid.
    always_ff @(posedge clk50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.word_done  = word_done_q;
    assign bus.serial_out = (state_q == ST_SHIFT) && (lsb_q ? shift_q[0] : shift_q[SR_W-1]);
    assign state_dbg      = state_q[0];
endmodule
